gpr_regfile: RTL and testbench

General-purpose register file for the RV64 decode stage: 32 × XLEN registers, two combinational read ports, one synchronous write port. Write targeting uses a key/value lookup mux (`ysyx_22050039_MuxKey`) as a 5→32 one-hot decoder. Each register is an instance of a generic enabled register (`ysyx_22050039_Reg`). Register x0 reads zero permanently. The block sits inside the IDU, which feeds it the execute result as write data and uses its read ports to form operands.

---
 rtl/gpr_regfile_pkg.sv | 26 ++
 rtl/ysyx_22050039_MuxKey.sv | 32 +++
 rtl/ysyx_22050039_Reg.sv | 39 +++
 rtl/gpr_regfile.sv | 84 ++++++++
 tb/tb_gpr_regfile.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/gpr_regfile_pkg.sv
// Shared constants for the RV64 general-purpose register file.
// Holds the architectural sizes and the ABI register-index names
// used by the decode stage when it refers to fixed registers.
package gpr_regfile_pkg;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned NR_REG  = 32;
  localparam int unsigned REG_SEL = 5;

  typedef logic [REG_SEL-1:0] reg_idx_t;

  // ABI register indices.
  localparam reg_idx_t RegZero = 5'd0;
  localparam reg_idx_t RegRa   = 5'd1;
  localparam reg_idx_t RegSp   = 5'd2;
  localparam reg_idx_t RegGp   = 5'd3;
  localparam reg_idx_t RegTp   = 5'd4;
  localparam reg_idx_t RegT0   = 5'd5;
  localparam reg_idx_t RegT1   = 5'd6;
  localparam reg_idx_t RegT2   = 5'd7;
  localparam reg_idx_t RegS0   = 5'd8;
  localparam reg_idx_t RegS1   = 5'd9;
  localparam reg_idx_t RegA0   = 5'd10;
  localparam reg_idx_t RegA1   = 5'd11;

endpackage

// File: rtl/ysyx_22050039_MuxKey.sv
// Generic combinational key/value lookup mux.
// Ports:
//   out - data of the first pair whose key matches, else zero
//   key - lookup key
//   lut - NR_KEY packed {key, data} pairs, first pair in the MSBs
module ysyx_22050039_MuxKey #(
  parameter int unsigned NR_KEY   = 2,
  parameter int unsigned KEY_LEN  = 1,
  parameter int unsigned DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);

  localparam int unsigned PairLen = KEY_LEN + DATA_LEN;

  logic found;

  // Scan from the first-listed pair; the found flag makes the earliest match win.
  always_comb begin
    out   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NR_KEY; i++) begin
      if (!found && (lut[(NR_KEY-i)*PairLen-1 -: KEY_LEN] == key)) begin
        out   = lut[(NR_KEY-i)*PairLen-KEY_LEN-1 -: DATA_LEN];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ysyx_22050039_Reg.sv
// Generic enabled register with synchronous active-high reset.
// Ports:
//   clk  - clock, updates on rising edge
//   rst  - synchronous reset, loads RESET_VAL (wins over wen)
//   din  - data to load when wen is set
//   dout - stored value
//   wen  - load enable
module ysyx_22050039_Reg #(
  parameter int unsigned             WIDTH     = 1,
  parameter logic        [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  input  logic             wen
);

  logic [WIDTH-1:0] dout_d;
  logic [WIDTH-1:0] dout_q;

  always_comb begin
    dout_d = dout_q;
    if (wen) begin
      dout_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/gpr_regfile.sv
// RV64 general-purpose register file: NR_REG x XLEN, two combinational
// read ports, one synchronous write port. x0 always reads zero.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset, clears every register
//   wdata  - write data
//   rd     - destination register index
//   wen    - global write enable
//   rs1    - read port 1 index
//   rs2    - read port 2 index
//   rdata1 - contents of register rs1 (no write bypass)
//   rdata2 - contents of register rs2 (no write bypass)
module gpr_regfile
  import gpr_regfile_pkg::*;
#(
  parameter int unsigned XLEN    = gpr_regfile_pkg::XLEN,
  parameter int unsigned NR_REG  = gpr_regfile_pkg::NR_REG,
  parameter int unsigned REG_SEL = gpr_regfile_pkg::REG_SEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [XLEN-1:0]    wdata,
  input  logic [REG_SEL-1:0] rd,
  input  logic               wen,
  input  logic [REG_SEL-1:0] rs1,
  input  logic [REG_SEL-1:0] rs2,
  output logic [XLEN-1:0]    rdata1,
  output logic [XLEN-1:0]    rdata2
);

  localparam int unsigned PairLen = REG_SEL + NR_REG;

  logic [NR_REG*PairLen-1:0] rd_lut;
  logic [NR_REG-1:0]         rd_mask;
  logic [XLEN-1:0]           regs [NR_REG];

  // Decoder table: key i -> one-hot bit i, except key 0 -> empty mask.
  for (genvar i = 0; i < NR_REG; i++) begin : g_lut
    if (i == 0) begin : g_zero
      assign rd_lut[(NR_REG-i)*PairLen-1 -: PairLen] = {REG_SEL'(i), {NR_REG{1'b0}}};
    end else begin : g_onehot
      assign rd_lut[(NR_REG-i)*PairLen-1 -: PairLen] = {REG_SEL'(i), NR_REG'(1) << i};
    end
  end

  ysyx_22050039_MuxKey #(
    .NR_KEY  (NR_REG),
    .KEY_LEN (REG_SEL),
    .DATA_LEN(NR_REG)
  ) u_rd_dec (
    .out(rd_mask),
    .key(rd),
    .lut(rd_lut)
  );

  for (genvar i = 0; i < NR_REG; i++) begin : g_reg
    logic reg_wen;
    if (i == 0) begin : g_x0
      // x0 is never written, so it keeps its reset value of zero.
      assign reg_wen = 1'b0;
    end else begin : g_xn
      assign reg_wen = wen & rd_mask[i];
    end

    ysyx_22050039_Reg #(
      .WIDTH    (XLEN),
      .RESET_VAL({XLEN{1'b0}})
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .din (wdata),
      .dout(regs[i]),
      .wen (reg_wen)
    );
  end

  // Bit 0 of the mask is always clear and has no consumer.
  logic unused_mask0;
  assign unused_mask0 = rd_mask[0];

  assign rdata1 = regs[rs1];
  assign rdata2 = regs[rs2];

endmodule

// File: tb/tb_gpr_regfile.sv
module tb_gpr_regfile;

  logic        clk;
  logic        rst;
  logic [63:0] wdata;
  logic [4:0]  rd;
  logic        wen;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [63:0] rdata1;
  logic [63:0] rdata2;

  int total;
  int bad;

  logic [63:0] model [32];

  gpr_regfile dut (
    .clk   (clk),
    .rst   (rst),
    .wdata (wdata),
    .rd    (rd),
    .wen   (wen),
    .rs1   (rs1),
    .rs2   (rs2),
    .rdata1(rdata1),
    .rdata2(rdata2)
  );

  // Standalone lookup-mux instances.
  logic [1:0] mk_key;
  logic [3:0] mk4_out;
  logic [3:0] mk3_out;
  logic [3:0] mkd_out;
  logic [23:0] mk4_lut;
  logic [17:0] mk3_lut;
  logic [11:0] mkd_lut;

  assign mk4_lut = {2'd0, 4'hA, 2'd1, 4'hB, 2'd2, 4'hC, 2'd3, 4'hD};
  assign mk3_lut = {2'd0, 4'hA, 2'd1, 4'hB, 2'd2, 4'hC};
  assign mkd_lut = {2'd2, 4'h7, 2'd2, 4'h3};

  ysyx_22050039_MuxKey #(.NR_KEY(4), .KEY_LEN(2), .DATA_LEN(4)) u_mk4 (
    .out(mk4_out), .key(mk_key), .lut(mk4_lut)
  );
  ysyx_22050039_MuxKey #(.NR_KEY(3), .KEY_LEN(2), .DATA_LEN(4)) u_mk3 (
    .out(mk3_out), .key(mk_key), .lut(mk3_lut)
  );
  ysyx_22050039_MuxKey #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(4)) u_mkd (
    .out(mkd_out), .key(mk_key), .lut(mkd_lut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        wen;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] exp1;
    logic [63:0] exp2;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the architectural effect of one rising edge.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
    end else if (wen && rd != 5'd0) begin
      model[rd] = wdata;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b0; wen = 1'b0; rd = '0; wdata = '0; rs1 = '0; rs2 = '0; mk_key = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    vecs[0] = '{1'b1, 1'b1, 5'd5, 64'hFFFF, 5'd5, 5'd0, 64'h0, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 5'd3, 64'h0123_4567_89AB_CDEF, 5'd3, 5'd3,
                64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF};
    vecs[2] = '{1'b0, 1'b1, 5'd0, 64'hDEAD, 5'd0, 5'd3, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[3] = '{1'b0, 1'b0, 5'd7, 64'h55, 5'd7, 5'd3, 64'h0, 64'h0123_4567_89AB_CDEF};
    vecs[4] = '{1'b0, 1'b1, 5'd7, 64'h55, 5'd7, 5'd5, 64'h55, 64'h0};
    vecs[5] = '{1'b0, 1'b1, 5'd3, 64'h1, 5'd3, 5'd7, 64'h1, 64'h55};
    vecs[6] = '{1'b1, 1'b1, 5'd9, 64'h9, 5'd3, 5'd7, 64'h0, 64'h0};
    vecs[7] = '{1'b0, 1'b1, 5'd9, 64'hFFFF_FFFF_FFFF_FFFF, 5'd9, 5'd9,
                64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};

    #2;
    for (int v = 0; v < 8; v++) begin
      rst = vecs[v].rst; wen = vecs[v].wen; rd = vecs[v].rd; wdata = vecs[v].wdata;
      rs1 = vecs[v].rs1; rs2 = vecs[v].rs2;
      tick();
      check($sformatf("vec%0d_rdata1", v), rdata1, vecs[v].exp1);
      check($sformatf("vec%0d_rdata2", v), rdata2, vecs[v].exp2);
      if (v == 0) begin
        rst = 1'b0; wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
          rs1 = 5'(i); rs2 = 5'(31 - i);
          #1;
          check($sformatf("reset_zero_r%0d", i), rdata1, 64'h0);
        end
      end
    end

    // No bypass: r9 holds all-ones, r10 was cleared by the reset vector.
    rst = 1'b0; wen = 1'b1; rd = 5'd10; wdata = 64'hAA; rs1 = 5'd10; rs2 = 5'd9;
    #1;
    check("nobypass_before_edge", rdata1, 64'h0);
    tick();
    check("nobypass_after_edge", rdata1, 64'hAA);
    check("nobypass_other_port", rdata2, 64'hFFFF_FFFF_FFFF_FFFF);

    // Sweep r1..r31, then read everything back on both ports.
    for (int i = 1; i < 32; i++) begin
      wen = 1'b1; rd = 5'(i); wdata = 64'(i) * 64'h1111;
      tick();
    end
    wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(31 - i);
      #1;
      check($sformatf("sweep_rs1_r%0d", i), rdata1, 64'(i) * 64'h1111);
      check($sformatf("sweep_rs2_r%0d", 31 - i), rdata2, 64'(31 - i) * 64'h1111);
    end

    // Randomized traffic against the array model; reads checked before each edge.
    for (int n = 0; n < 600; n++) begin
      rst   = ($urandom_range(0, 31) == 0);
      wen   = 1'($urandom_range(0, 1));
      rd    = 5'($urandom_range(0, 31));
      wdata = {$urandom, $urandom};
      rs1   = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
      rs2   = ($urandom_range(0, 7) == 0) ? rs1 : 5'($urandom_range(0, 31));
      #1;
      check($sformatf("rand%0d_rdata1", n), rdata1, model[rs1]);
      check($sformatf("rand%0d_rdata2", n), rdata2, model[rs2]);
      tick();
    end
    rst = 1'b0; wen = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i); rs2 = 5'(i);
      #1;
      check($sformatf("final_r%0d", i), rdata1, model[i]);
    end

    // Standalone lookup-mux checks.
    for (int k = 0; k < 4; k++) begin
      mk_key = 2'(k);
      #1;
      check($sformatf("mk4_key%0d", k), 64'(mk4_out), 64'(4'hA + 4'(k)));
      check($sformatf("mk3_key%0d", k), 64'(mk3_out), (k < 3) ? 64'(4'hA + 4'(k)) : 64'h0);
      check($sformatf("mkdup_key%0d", k), 64'(mkd_out), (k == 2) ? 64'h7 : 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
